pong_game_fsm: RTL and testbench
================================

PONG_GAME_FSM -- requirements
Module: pong_game_fsm

Interface
REQ-001 Parameter WIN_SCORE, default 7, points needed to win (1..15).
REQ-002 Parameter SERVE_FRAMES, default 120, frame ticks held in SERVE before play.
REQ-003 Parameter POINT_FRAMES, default 60, frame ticks held in POINT after a score.
REQ-004 Parameter LEFT_LIMIT, default 2, ball_x strictly below this is a left miss.
REQ-005 Parameter RIGHT_LIMIT, default 638, ball_x strictly above this is a right miss.
REQ-006 clk_out  in  1  system clock (pixel clock domain).
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 frame_tick  in  1  one-cycle pulse per video frame.
REQ-009 start  in  1  start/pause button level, already synchronized.
REQ-010 ball_x  in  10  current ball centre x-coordinate, unsigned.
REQ-011 ball_enable  out  1  high only while the ball may move.
REQ-012 ball_restart  out  1  one-cycle pulse recentring the ball.
REQ-013 serve_dir  out  1  0 = serve toward P1 (left), 1 = toward P2 (right).
REQ-014 p1_score, p2_score  out  4 each  current scores.
REQ-015 winner  out  2  00 none, 01 P1, 10 P2.
REQ-016 state  out  3  encoded state: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, POINT=4, GAME_OVER=5.

Function
REQ-017 start_edge SHALL be start AND NOT start_q, with start_q a register of start that resets to 0.
REQ-018 All outputs SHALL be registered or decoded from registered state only; no combinational path from any input to any output.
REQ-019 An 8-bit frame counter SHALL clear on every state change and increment on frame_tick in SERVE and POINT.
REQ-020 IDLE: scores, winner and serve_dir SHALL hold 0, ball_enable SHALL be 0, and start_edge SHALL move the FSM to SERVE.
REQ-021 Every entry into SERVE SHALL assert ball_restart for exactly the first cycle in which state reads SERVE.
REQ-022 SERVE: ball_enable SHALL be 0, and the FSM SHALL move to PLAY on the frame_tick that brings the counter to SERVE_FRAMES.
REQ-023 PLAY: ball_enable SHALL be 1; the left-miss check SHALL take priority, then the right-miss check, then start_edge.
REQ-024 PLAY, ball_x < LEFT_LIMIT: p2_score SHALL increment by 1, serve_dir SHALL become 0, and the FSM SHALL move to POINT, all in one cycle.
REQ-025 PLAY, ball_x > RIGHT_LIMIT: p1_score SHALL increment by 1, serve_dir SHALL become 1, and the FSM SHALL move to POINT.
REQ-026 PLAY, start_edge with no miss: the FSM SHALL move to PAUSE.
REQ-027 PAUSE: ball_enable SHALL be 0, start_edge SHALL return the FSM to PLAY, and frame_tick SHALL be ignored.
REQ-028 POINT: ball_enable SHALL be 0; after POINT_FRAMES ticks the FSM SHALL go to GAME_OVER if either score equals WIN_SCORE, else to SERVE.
REQ-029 Each scored point SHALL increment a score exactly once; a score SHALL never exceed WIN_SCORE.
REQ-030 GAME_OVER: winner SHALL be 01 if p1_score equals WIN_SCORE, else 10, and ball_enable SHALL be 0.
REQ-031 GAME_OVER, start_edge: the FSM SHALL clear scores, winner and serve_dir, and move to SERVE, asserting ball_restart.
REQ-032 Any unused state encoding SHALL return to IDLE on the next clock.
REQ-033 frame_tick coincident with a state change SHALL not count toward the new state.

Reset
REQ-034 Reset SHALL force, asynchronously and at any time including mid-SERVE or mid-POINT: state IDLE, every output 0, frame counter 0, start_q 0.
REQ-035 start held high through reset release SHALL produce one start_edge on the first clock after release.

Verification (bench parameters: WIN_SCORE=3, SERVE_FRAMES=2, POINT_FRAMES=2)
REQ-036 Reset, then pulse start -> state 1 with ball_restart high for 1 cycle; after 2 frame_ticks -> state 2 with ball_enable 1.
REQ-037 In PLAY, drive ball_x=1 and hold it for 5 cycles -> p2_score=1 (single increment), serve_dir 0, state 4; after 2 ticks -> state 1 with ball_restart pulse.
REQ-038 Score P1 three times with ball_x=639 -> after the third POINT, state 5, winner 01, p1_score 3; start edge -> scores 0, state 1.
REQ-039 In PLAY, pulse start -> state 3 and ball_enable 0; frame_ticks leave the state unchanged; second start pulse -> state 2.
REQ-040 In PLAY, drive ball_x=0 and a start edge in the same cycle -> state 4 (miss wins), p2_score increments.
REQ-041 Assert reset mid-POINT with p1_score=2 -> immediate state 0 with all outputs 0 before the next clk_out edge.

Source files
------------

// File: rtl/pong_game_fsm.sv
// Pong match controller: sequences serve, play, pause, point and game-over,
// keeps both scores and gates ball motion. Outputs come from registers only.
module pong_game_fsm #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 120,
  parameter int POINT_FRAMES = 60,
  parameter int LEFT_LIMIT   = 2,
  parameter int RIGHT_LIMIT  = 638
) (
  input  logic       clk_out,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] ball_x,
  output logic       ball_enable,
  output logic       ball_restart,
  output logic       serve_dir,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_POINT = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  localparam logic [3:0] WIN   = 4'(WIN_SCORE);
  localparam logic [7:0] SRV_N = 8'(SERVE_FRAMES);
  localparam logic [7:0] PNT_N = 8'(POINT_FRAMES);
  localparam logic [9:0] LEFT_X  = 10'(LEFT_LIMIT);
  localparam logic [9:0] RIGHT_X = 10'(RIGHT_LIMIT);

  logic [2:0] state_q, state_d;
  logic       start_q;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] p1_q, p1_d;
  logic [3:0] p2_q, p2_d;
  logic       dir_q, dir_d;
  logic       restart_q, restart_d;

  logic       start_edge;
  logic       left_miss;
  logic       right_miss;
  logic [7:0] cnt_inc;
  logic       match_won;

  assign start_edge = start & ~start_q;
  assign left_miss  = ball_x < LEFT_X;
  assign right_miss = ball_x > RIGHT_X;
  assign cnt_inc    = cnt_q + 8'd1;
  assign match_won  = (p1_q == WIN) || (p2_q == WIN);

  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      cnt_q     <= 8'd0;
      p1_q      <= 4'd0;
      p2_q      <= 4'd0;
      dir_q     <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      cnt_q     <= cnt_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      dir_q     <= dir_d;
      restart_q <= restart_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_edge) state_d = S_SERVE;
      S_SERVE: if (frame_tick && cnt_inc == SRV_N)
                 state_d = S_PLAY;
      // A miss outranks a pause request in the same cycle
      S_PLAY: begin
        if (left_miss || right_miss)
          state_d = S_POINT;
        else if (start_edge)
          state_d = S_PAUSE;
      end
      S_PAUSE: if (start_edge) state_d = S_PLAY;
      S_POINT: begin
        if (frame_tick && cnt_inc == PNT_N)
          state_d = match_won ? S_OVER : S_SERVE;
      end
      S_OVER:  if (start_edge) state_d = S_SERVE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    p1_d  = p1_q;
    p2_d  = p2_q;
    dir_d = dir_q;
    cnt_d = cnt_q;
    // Ticks landing on a transition belong to neither state
    if (state_d != state_q)
      cnt_d = 8'd0;
    else if (frame_tick &&
             (state_q == S_SERVE || state_q == S_POINT))
      cnt_d = cnt_inc;
    restart_d = (state_d == S_SERVE) &&
                (state_q != S_SERVE);
    case (state_q)
      S_PLAY: begin
        if (left_miss) begin
          if (p2_q < WIN) p2_d = p2_q + 4'd1;
          dir_d = 1'b0;
        end else if (right_miss) begin
          if (p1_q < WIN) p1_d = p1_q + 4'd1;
          dir_d = 1'b1;
        end
      end
      S_SERVE, S_PAUSE, S_POINT: begin
      end
      S_OVER: begin
        if (start_edge) begin
          p1_d  = 4'd0;
          p2_d  = 4'd0;
          dir_d = 1'b0;
        end
      end
      default: begin
        p1_d  = 4'd0;
        p2_d  = 4'd0;
        dir_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    ball_enable  = (state_q == S_PLAY);
    ball_restart = restart_q;
    serve_dir    = dir_q;
    p1_score     = p1_q;
    p2_score     = p2_q;
    state        = state_q;
    winner       = 2'b00;
    if (state_q == S_OVER)
      winner = (p1_q == WIN) ? 2'b01 : 2'b10;
  end

endmodule

// File: tb/tb_pong_game_fsm.sv
// Directed bench for pong_game_fsm: expected output snapshots are queued
// by the stimulus and matched by a monitor on every observed change.
module tb_pong_game_fsm;

  logic       clk_out = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic [9:0] ball_x = 10'd320;
  logic       ball_enable;
  logic       ball_restart;
  logic       serve_dir;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] winner;
  logic [2:0] state;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] p1;
    logic [3:0] p2;
    logic       sd;
    logic [1:0] win;
    logic       en;
    logic       rs;
  } snap_t;

  snap_t exp_q[$];
  string name_q[$];
  int checks = 0;
  int errors = 0;

  pong_game_fsm #(
    .WIN_SCORE(3),
    .SERVE_FRAMES(2),
    .POINT_FRAMES(2)
  ) dut (
    .clk_out(clk_out),
    .reset(reset),
    .frame_tick(frame_tick),
    .start(start),
    .ball_x(ball_x),
    .ball_enable(ball_enable),
    .ball_restart(ball_restart),
    .serve_dir(serve_dir),
    .p1_score(p1_score),
    .p2_score(p2_score),
    .winner(winner),
    .state(state)
  );

  always #5 clk_out = ~clk_out;

  function automatic string fmt(snap_t s);
    return $sformatf("st=%0d p1=%0d p2=%0d dir=%0b win=%b en=%0b rs=%0b",
                     s.st, s.p1, s.p2, s.sd, s.win, s.en, s.rs);
  endfunction

  task automatic push(input string n, input logic [2:0] st,
                      input logic [3:0] p1, input logic [3:0] p2,
                      input logic sd, input logic [1:0] win,
                      input logic en, input logic rs);
    snap_t s;
    s.st = st; s.p1 = p1; s.p2 = p2; s.sd = sd;
    s.win = win; s.en = en; s.rs = rs;
    exp_q.push_back(s);
    name_q.push_back(n);
  endtask

  task automatic push_serve(input string n, input logic [3:0] p1,
                            input logic [3:0] p2, input logic sd);
    push({n, "_restart"}, 3'd1, p1, p2, sd, 2'b00, 1'b0, 1'b1);
    push({n, "_hold"}, 3'd1, p1, p2, sd, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk_out);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic score(input logic [9:0] x, input int hold);
    ball_x = x;
    for (int i = 0; i < hold; i++) step();
    ball_x = 10'd320;
  endtask

  initial begin : monitor
    snap_t cur, last, exp;
    string nm;
    last = '1;
    forever begin
      @(negedge clk_out or posedge reset);
      #1;
      cur = {state, p1_score, p2_score, serve_dir,
             winner, ball_enable, ball_restart};
      if (cur !== last) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got %s required no change",
                   fmt(cur));
        end else begin
          exp = exp_q.pop_front();
          nm = name_q.pop_front();
          if (cur !== exp) begin
            errors++;
            $display("FAIL %s: got %s required %s", nm, fmt(cur),
                     fmt(exp));
          end
        end
        last = cur;
      end
    end
  end

  initial begin : stimulus
    push("reset", 3'd0, 4'd0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    #1 reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();

    push_serve("serve1", 4'd0, 4'd0, 1'b0);
    pulse_start();
    push("play1", 3'd2, 4'd0, 4'd0, 1'b0, 2'b00, 1'b1, 1'b0);
    pulse_tick();
    pulse_tick();

    push("left_miss", 3'd4, 4'd0, 4'd1, 1'b0, 2'b00, 1'b0, 1'b0);
    score(10'd1, 5);
    push_serve("serve2", 4'd0, 4'd1, 1'b0);
    pulse_tick();
    pulse_tick();
    push("play2", 3'd2, 4'd0, 4'd1, 1'b0, 2'b00, 1'b1, 1'b0);
    pulse_tick();
    pulse_tick();

    push("pause", 3'd3, 4'd0, 4'd1, 1'b0, 2'b00, 1'b0, 1'b0);
    pulse_start();
    repeat (3) pulse_tick();
    push("resume", 3'd2, 4'd0, 4'd1, 1'b0, 2'b00, 1'b1, 1'b0);
    pulse_start();

    push("miss_over_start", 3'd4, 4'd0, 4'd2, 1'b0, 2'b00,
         1'b0, 1'b0);
    ball_x = 10'd0;
    start = 1'b1;
    step();
    ball_x = 10'd320;
    start = 1'b0;
    step();
    push_serve("serve3", 4'd0, 4'd2, 1'b0);
    pulse_tick();
    pulse_tick();
    push("play3", 3'd2, 4'd0, 4'd2, 1'b0, 2'b00, 1'b1, 1'b0);
    pulse_tick();
    pulse_tick();

    for (int k = 1; k <= 3; k++) begin
      push($sformatf("right_miss%0d", k), 3'd4, 4'(k), 4'd2, 1'b1,
           2'b00, 1'b0, 1'b0);
      score(10'd639, 1);
      step();
      if (k < 3) begin
        push_serve($sformatf("serve_p1_%0d", k), 4'(k), 4'd2, 1'b1);
        pulse_tick();
        pulse_tick();
        push($sformatf("play_p1_%0d", k), 3'd2, 4'(k), 4'd2, 1'b1,
             2'b00, 1'b1, 1'b0);
        pulse_tick();
        pulse_tick();
      end
    end
    push("game_over", 3'd5, 4'd3, 4'd2, 1'b1, 2'b01, 1'b0, 1'b0);
    pulse_tick();
    pulse_tick();
    repeat (2) pulse_tick();
    push_serve("new_match", 4'd0, 4'd0, 1'b0);
    pulse_start();

    push("play4", 3'd2, 4'd0, 4'd0, 1'b0, 2'b00, 1'b1, 1'b0);
    pulse_tick();
    pulse_tick();
    push("p1_a", 3'd4, 4'd1, 4'd0, 1'b1, 2'b00, 1'b0, 1'b0);
    score(10'd700, 1);
    push_serve("serve4", 4'd1, 4'd0, 1'b1);
    pulse_tick();
    pulse_tick();
    push("play5", 3'd2, 4'd1, 4'd0, 1'b1, 2'b00, 1'b1, 1'b0);
    pulse_tick();
    pulse_tick();
    push("p1_b", 3'd4, 4'd2, 4'd0, 1'b1, 2'b00, 1'b0, 1'b0);
    score(10'd639, 1);
    pulse_tick();

    push("reset_mid_point", 3'd0, 4'd0, 4'd0, 1'b0, 2'b00,
         1'b0, 1'b0);
    #1 reset = 1'b1;
    repeat (2) step();

    start = 1'b1;
    push_serve("start_thru_reset", 4'd0, 4'd0, 1'b0);
    reset = 1'b0;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    pulse_tick();
    push("play6", 3'd2, 4'd0, 4'd0, 1'b0, 2'b00, 1'b1, 1'b0);
    pulse_tick();
    start = 1'b0;
    repeat (4) step();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d pending required 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
